l4_trigger_delay: RTL and testbench
===================================

Name: l4_trigger_delay

Overview:
- Consumes the packed per-L4 pretrigger and delay vectors built from the five L4 sources (rf0, rf1, cpu, cal, ext).
- Delays each incoming L4 trigger pulse by its programmed delay.
- Merges all expiring triggers into one trigger strobe. The strobe carries a type mask and the pretrigger depth the readout must use.
- Sits between the L4 trigger logic and the event readout/block manager.

Parameters:
- NUM_L4, 5, number of L4 sources. Index 0 = rf0, 1 = rf1, 2 = cpu, 3 = cal, 4 = ext.
- DELAY_BITS, 8, width of each delay field.
- PRETRG_BITS, 4, width of each pretrigger field.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- l4_i  in  NUM_L4  single-cycle L4 trigger pulses, one bit per source.
- l4_enable_i  in  NUM_L4  per-source enable. A disabled source ignores l4_i.
- delay_vector_i  in  DELAY_BITS*NUM_L4  packed delays; source i occupies bits [i*DELAY_BITS +: DELAY_BITS].
- pretrigger_vector_i  in  PRETRG_BITS*NUM_L4  packed pretrigger depths, same packing as delay_vector_i.
- dropped_clr_i  in  1  clears the dropped_o flags.
- busy_o  out  NUM_L4  source i has a trigger in flight.
- dropped_o  out  NUM_L4  sticky flag: a trigger on source i was discarded because that source was busy.
- trig_o  out  1  merged delayed trigger strobe, one cycle wide.
- trig_type_o  out  NUM_L4  mask of sources expiring in the trig_o cycle.
- trig_pretrigger_o  out  PRETRG_BITS  maximum pretrigger depth among the sources in trig_type_o.

Behaviour:
- Reset (rst_n_i low, asynchronous): all counters = 0; busy_o = 0; dropped_o = 0; trig_o = 0; trig_type_o = 0; trig_pretrigger_o = 0.
- Per-source channel, two states: IDLE and COUNT.
- IDLE -> COUNT when l4_i[i] & l4_enable_i[i]:
  - Latch the delay field into the down-counter.
  - Latch the pretrigger field into a holding register.
  - Later changes to either vector do not affect the trigger in flight.
- COUNT: the counter decrements each cycle. When the counter is 0, the channel expires and returns to IDLE.
- Latency: a pulse on l4_i in cycle N with delay D produces trig_o in cycle N+D+1. D = 0 gives N+1. D = 255 gives N+256.
- busy_o[i] is 1 from cycle N+1 through cycle N+D+1 inclusive (registered, equals "state == COUNT").
- Retrigger on a source in COUNT:
  - The new pulse is discarded and dropped_o[i] is set the next cycle.
  - This applies to the expiry cycle too, since a channel is only re-armed from IDLE.
- A pulse arriving the cycle after expiry is accepted.
- dropped_o:
  - Sticky.
  - dropped_clr_i clears all bits the next cycle.
  - A simultaneous clear and new drop leaves the bit set (set wins).
- Merge, all outputs registered:
  - trig_o = OR of the expiring channels.
  - trig_type_o = mask of the expiring channels.
  - trig_pretrigger_o = unsigned maximum of their latched pretrigger values.
  - When trig_o = 0, trig_type_o and trig_pretrigger_o are 0.
- Disabled source: a pulse on a source with l4_enable_i[i] = 0 is ignored, with no drop flag. Deasserting the enable mid-COUNT does not cancel the trigger in flight.
- Reset mid-COUNT: all in-flight triggers are abandoned and no trig_o is emitted.

Test Plan:
- rf0 delay = 10, pretrigger = 3, l4_i = 00001 at cycle 100 -> trig_o at cycle 111, trig_type_o = 00001, trig_pretrigger_o = 3. busy_o[0] high cycles 101-111.
- cpu delay = 0, l4_i[2] pulse at cycle 50 -> trig_o at cycle 51, type = 00100.
- rf1 delay = 5 / pretrig = 2 and cal delay = 3 / pretrig = 7; rf1 pulse at cycle 0, cal pulse at cycle 2 -> single trig_o at cycle 6, type = 01010, pretrigger = 7.
- ext delay = 20; pulses at cycles 0 and 5 -> one trig_o at cycle 21; dropped_o[4] = 1 from cycle 6. dropped_clr_i at cycle 30 -> dropped_o = 0 at cycle 31.
- rf0 delay = 4, pulse at cycle 0, delay_vector_i changed to 50 at cycle 1 -> trig_o still at cycle 5. Pulse with l4_enable_i[0] = 0 -> no busy, no drop, no trig.
- Pulse at cycle 0 with delay 8, rst_n_i low during cycles 3-4 -> no trig_o; all outputs 0 from cycle 3 onward.

Source files
------------

// File: rtl/l4_trigger_delay.sv
// Purpose : delays each L4 source trigger by its programmed delay and merges
//           the expiring triggers into one strobe with a type mask and pretrigger depth.
// Latency : a pulse in cycle N with delay D gives trig_o in cycle N+D+1. There is no backpressure:
//           a retrigger on a busy source is discarded and flagged in dropped_o.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   l4_i, l4_enable_i     per-source trigger pulses and enables
//   delay_vector_i        packed per-source delays, source i at [i*DELAY_BITS +: DELAY_BITS]
//   pretrigger_vector_i   packed per-source pretrigger depths, same packing
//   dropped_clr_i         clears the sticky dropped_o flags
//   busy_o, dropped_o     per-source in-flight flag and sticky drop flag
//   trig_o, trig_type_o,  merged strobe, mask of expiring sources, and the
//   trig_pretrigger_o     maximum latched pretrigger depth among them
module l4_trigger_delay #(
  parameter int NUM_L4      = 5,
  parameter int DELAY_BITS  = 8,
  parameter int PRETRG_BITS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_L4-1:0]             l4_i,
  input  logic [NUM_L4-1:0]             l4_enable_i,
  input  logic [DELAY_BITS*NUM_L4-1:0]  delay_vector_i,
  input  logic [PRETRG_BITS*NUM_L4-1:0] pretrigger_vector_i,
  input  logic                          dropped_clr_i,
  output logic [NUM_L4-1:0]             busy_o,
  output logic [NUM_L4-1:0]             dropped_o,
  output logic                          trig_o,
  output logic [NUM_L4-1:0]             trig_type_o,
  output logic [PRETRG_BITS-1:0]        trig_pretrigger_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state_q [NUM_L4];
  state_t                 state_d [NUM_L4];
  logic [DELAY_BITS-1:0]  cnt_q   [NUM_L4];
  logic [DELAY_BITS-1:0]  cnt_d   [NUM_L4];
  logic [PRETRG_BITS-1:0] pre_q   [NUM_L4];
  logic [PRETRG_BITS-1:0] pre_d   [NUM_L4];
  // Pretrigger value that belongs to a channel expiring next cycle. For a
  // zero delay the channel fires straight out of IDLE, so the value must come
  // from the input vector rather than the not-yet-loaded holding register.
  logic [PRETRG_BITS-1:0] pre_src [NUM_L4];

  logic [NUM_L4-1:0]      fire_nxt;
  logic [NUM_L4-1:0]      drop_nxt;
  logic [PRETRG_BITS-1:0] pre_max;

  logic [NUM_L4-1:0]      dropped_q;
  logic                   trig_q;
  logic [NUM_L4-1:0]      trig_type_q;
  logic [PRETRG_BITS-1:0] trig_pre_q;

  // Per-channel next-state logic. The merged outputs are registered, so
  // expiry is detected one cycle early: a channel that fires in cycle N+D+1
  // (counter reaching 0) is flagged while its counter is still 1, or at
  // arm time when D = 0.
  always_comb begin
    for (int i = 0; i < NUM_L4; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      pre_d[i]    = pre_q[i];
      pre_src[i]  = pre_q[i];
      fire_nxt[i] = 1'b0;
      drop_nxt[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (l4_i[i] && l4_enable_i[i]) begin
            state_d[i]  = COUNT;
            cnt_d[i]    = delay_vector_i[i*DELAY_BITS +: DELAY_BITS];
            pre_d[i]    = pretrigger_vector_i[i*PRETRG_BITS +: PRETRG_BITS];
            pre_src[i]  = pretrigger_vector_i[i*PRETRG_BITS +: PRETRG_BITS];
            fire_nxt[i] = (delay_vector_i[i*DELAY_BITS +: DELAY_BITS] == '0);
          end
        end
        COUNT: begin
          // Re-arming only happens from IDLE, so a pulse in the expiry
          // cycle is dropped as well.
          drop_nxt[i] = l4_i[i] && l4_enable_i[i];
          fire_nxt[i] = (cnt_q[i] == DELAY_BITS'(1));
          if (cnt_q[i] == '0) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - DELAY_BITS'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Unsigned maximum pretrigger across the channels expiring next cycle.
  always_comb begin
    pre_max = '0;
    for (int i = 0; i < NUM_L4; i++) begin
      if (fire_nxt[i] && (pre_src[i] > pre_max)) begin
        pre_max = pre_src[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_L4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pre_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_L4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pre_q[i]   <= pre_d[i];
      end
    end
  end

  // Sticky drop flags: a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= (dropped_q & ~{NUM_L4{dropped_clr_i}}) | drop_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_q      <= 1'b0;
      trig_type_q <= '0;
      trig_pre_q  <= '0;
    end else begin
      trig_q      <= |fire_nxt;
      trig_type_q <= fire_nxt;
      trig_pre_q  <= pre_max;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_L4; i++) begin
      busy_o[i] = (state_q[i] == COUNT);
    end
  end

  assign dropped_o         = dropped_q;
  assign trig_o            = trig_q;
  assign trig_type_o       = trig_type_q;
  assign trig_pretrigger_o = trig_pre_q;

endmodule

// File: tb/tb_l4_trigger_delay.sv
// Directed bench for l4_trigger_delay: delay latency, merge, drops, enables,
// latching of the programmed fields, and reset while triggers are in flight.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_l4_trigger_delay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  l4;
  logic [4:0]  l4_en;
  logic [39:0] dly_vec;
  logic [19:0] pre_vec;
  logic        clr;
  logic [4:0]  busy;
  logic [4:0]  dropped;
  logic        trig;
  logic [4:0]  trig_type;
  logic [3:0]  trig_pre;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l4_trigger_delay #(
    .NUM_L4(5),
    .DELAY_BITS(8),
    .PRETRG_BITS(4)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .l4_i               (l4),
    .l4_enable_i        (l4_en),
    .delay_vector_i     (dly_vec),
    .pretrigger_vector_i(pre_vec),
    .dropped_clr_i      (clr),
    .busy_o             (busy),
    .dropped_o          (dropped),
    .trig_o             (trig),
    .trig_type_o        (trig_type),
    .trig_pretrigger_o  (trig_pre)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dly(input int i, input logic [7:0] v);
    dly_vec[i*8 +: 8] = v;
  endtask

  task automatic set_pre(input int i, input logic [3:0] v);
    pre_vec[i*4 +: 4] = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_trig"}, 32'(trig), 32'd0);
    chk({tag, "_type"}, 32'(trig_type), 32'd0);
    chk({tag, "_pre"},  32'(trig_pre), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    l4      = '0;
    l4_en   = 5'b11111;
    dly_vec = '0;
    pre_vec = '0;
    clr     = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_dropped", 32'(dropped), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // rf0: delay 10, pretrigger 3 -> strobe 11 cycles after the pulse
    set_dly(0, 8'd10);
    set_pre(0, 4'd3);
    l4 = 5'b00001;
    chk("t1_busy_c0", 32'(busy), 32'd0);
    tick();
    l4 = '0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'b00001);
      chk($sformatf("t1_trig_c%0d", c), 32'(trig), 32'((c == 11) ? 1 : 0));
      if (c == 11) begin
        chk("t1_type", 32'(trig_type), 32'b00001);
        chk("t1_pre",  32'(trig_pre), 32'd3);
      end else begin
        tick();
      end
    end
    tick();
    chk_idle("t1_after");

    // cpu: delay 0 -> strobe the very next cycle
    set_dly(2, 8'd0);
    set_pre(2, 4'd5);
    l4 = 5'b00100;
    chk("t2_trig_c0", 32'(trig), 32'd0);
    tick();
    l4 = '0;
    chk("t2_trig_c1", 32'(trig), 32'd1);
    chk("t2_type_c1", 32'(trig_type), 32'b00100);
    chk("t2_pre_c1",  32'(trig_pre), 32'd5);
    chk("t2_busy_c1", 32'(busy), 32'b00100);
    tick();
    chk_idle("t2_after");

    // rf1 (5/2) at c0 and cal (3/7) at c2 coincide at c6 -> merged strobe
    set_dly(1, 8'd5);
    set_pre(1, 4'd2);
    set_dly(3, 8'd3);
    set_pre(3, 4'd7);
    l4 = 5'b00010;
    tick();
    l4 = '0;
    tick();
    l4 = 5'b01000;
    tick();
    l4 = '0;
    tick();
    tick();
    chk("t3_trig_c5", 32'(trig), 32'd0);
    chk("t3_busy_c5", 32'(busy), 32'b01010);
    tick();
    chk("t3_trig_c6", 32'(trig), 32'd1);
    chk("t3_type_c6", 32'(trig_type), 32'b01010);
    chk("t3_pre_c6",  32'(trig_pre), 32'd7);
    tick();
    chk_idle("t3_after");

    // ext: delay 20, retrigger at c5 is dropped; one strobe at c21
    set_dly(4, 8'd20);
    set_pre(4, 4'd1);
    l4 = 5'b10000;
    tick();
    l4 = '0;
    repeat (4) tick();
    l4 = 5'b10000;
    chk("t4_drop_c5", 32'(dropped), 32'd0);
    tick();
    l4 = '0;
    chk("t4_drop_c6", 32'(dropped), 32'b10000);
    chk("t4_busy_c6", 32'(busy), 32'b10000);
    repeat (14) tick();
    chk("t4_trig_c20", 32'(trig), 32'd0);
    tick();
    chk("t4_trig_c21", 32'(trig), 32'd1);
    chk("t4_type_c21", 32'(trig_type), 32'b10000);
    chk("t4_pre_c21",  32'(trig_pre), 32'd1);
    tick();
    chk("t4_trig_c22", 32'(trig), 32'd0);
    chk("t4_busy_c22", 32'(busy), 32'd0);
    repeat (8) tick();
    clr = 1'b1;
    chk("t4_drop_c30", 32'(dropped), 32'b10000);
    tick();
    clr = 1'b0;
    chk("t4_drop_c31", 32'(dropped), 32'd0);
    // delay 2 pulse at c31: busy c32..c34, strobe c34
    set_dly(4, 8'd2);
    l4 = 5'b10000;
    tick();
    chk("t4_busy_c32", 32'(busy), 32'b10000);
    clr = 1'b1;                 // drop and clear together: drop wins
    tick();
    l4  = '0;
    chk("t4_setwins", 32'(dropped), 32'b10000);
    tick();
    clr = 1'b0;
    chk("t4_clr2", 32'(dropped), 32'd0);
    chk("t4_trig_c34", 32'(trig), 32'd1);
    chk("t4_busy_c34", 32'(busy), 32'b10000);
    l4 = 5'b10000;              // pulse in expiry cycle is dropped
    tick();
    chk("t4_expdrop", 32'(dropped), 32'b10000);
    chk("t4_busy_c35", 32'(busy), 32'd0);
    chk("t4_trig_c35", 32'(trig), 32'd0);
    tick();                     // pulse the cycle after expiry is accepted
    l4 = '0;
    chk("t4_rearm", 32'(busy), 32'b10000);
    tick();
    tick();
    chk("t4_trig_c38", 32'(trig), 32'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr3", 32'(dropped), 32'd0);
    chk_idle("t4_after");

    // rf0: fields change after the pulse, the in-flight trigger keeps old ones
    set_dly(0, 8'd4);
    set_pre(0, 4'd1);
    l4 = 5'b00001;
    tick();
    l4 = '0;
    set_dly(0, 8'd50);
    set_pre(0, 4'd9);
    repeat (3) tick();
    chk("t5_trig_c4", 32'(trig), 32'd0);
    tick();
    chk("t5_trig_c5", 32'(trig), 32'd1);
    chk("t5_type_c5", 32'(trig_type), 32'b00001);
    chk("t5_pre_c5",  32'(trig_pre), 32'd1);
    tick();
    chk_idle("t5_after");

    // disabled source ignores pulses entirely
    l4_en = 5'b11110;
    l4    = 5'b00001;
    tick();
    l4 = '0;
    chk("t5_dis_busy", 32'(busy), 32'd0);
    chk("t5_dis_drop", 32'(dropped), 32'd0);
    for (int c = 0; c < 55; c++) begin
      chk($sformatf("t5_dis_trig%0d", c), 32'(trig), 32'd0);
      tick();
    end

    // disabling mid-count does not cancel the trigger
    l4_en = 5'b11111;
    set_dly(0, 8'd3);
    l4 = 5'b00001;
    tick();
    l4    = '0;
    l4_en = 5'b11110;
    repeat (2) tick();
    chk("t5_midoff_c3", 32'(trig), 32'd0);
    tick();
    chk("t5_midoff_c4", 32'(trig), 32'd1);
    l4_en = 5'b11111;
    tick();

    // reset during count abandons the trigger
    set_dly(0, 8'd8);
    l4 = 5'b00001;
    tick();
    l4 = '0;
    tick();
    chk("t6_busy_c2", 32'(busy), 32'b00001);
    tick();
    rst_n = 1'b0;
    #1;
    chk_idle("t6_rst_c3");
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 5; c <= 14; c++) begin
      chk($sformatf("t6_trig_c%0d", c), 32'(trig), 32'd0);
      chk($sformatf("t6_busy_c%0d", c), 32'(busy), 32'd0);
      tick();
    end
    chk("t6_dropped", 32'(dropped), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
